// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared widths, types and the shift/round/saturate function (RELU_EN: clamp negatives to zero)
package mvm_pkg;

    localparam int IN_W    = 28;
    localparam int OUT_W   = 14;
    localparam int SHIFT_W = 5;

    typedef logic signed [IN_W-1:0]  acc_t;
    typedef logic signed [OUT_W-1:0] data_t;

    typedef enum logic {
        IDLE,
        BUSY
    } rq_state_t;

    localparam logic [SHIFT_W-1:0]   SHIFT_MAX = SHIFT_W'(IN_W - 1);
    localparam logic signed [IN_W:0] SAT_HI    = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);
`ifdef RELU_EN
    localparam logic signed [IN_W:0] SAT_LO    = '0;
`else
    localparam logic signed [IN_W:0] SAT_LO    = (IN_W + 1)'(-(2 ** (OUT_W - 1)));
`endif

    // One extra bit of headroom so the rounding add cannot wrap.
    function automatic data_t sat_round(input acc_t x, input logic [SHIFT_W-1:0] s);
        logic [SHIFT_W-1:0]   sc;
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] rnd;
        logic signed [IN_W:0] r;
        sc  = (s > SHIFT_MAX) ? SHIFT_MAX : s;
        ext = {x[IN_W-1], x};
        rnd = ext;
        if (sc == '0) begin
            r = ext;
        end else begin
            rnd = ext + ((IN_W + 1)'(1) << (sc - 1'b1));
            r   = rnd >>> sc;
        end
`ifdef RELU_EN
        if (r < 0) r = '0;
`endif
        if (r > SAT_HI) return SAT_HI[OUT_W-1:0];
        if (r < SAT_LO) return SAT_LO[OUT_W-1:0];
        return r[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead FIFO with flop storage; DEPTH must be a power of two
module sync_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mvm_requant_out.sv
// rtl/mvm_requant_out.sv - requantise MVM row results, buffer one vector, tag the last row
module mvm_requant_out
    import mvm_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               input_valid,
    output logic               input_ready,
    input  acc_t               input_data,
    input  logic [SHIFT_W-1:0] shift_amt,
    output logic               output_valid,
    input  logic               output_ready,
    output data_t              output_data,
    output logic               output_last
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    rq_state_t          state;
    rq_state_t          state_next;
    logic [ROW_W-1:0]   in_row;
    logic [ROW_W-1:0]   in_row_next;
    logic [ROW_W-1:0]   out_row;
    logic [SHIFT_W-1:0] shift_r;
    logic [SHIFT_W-1:0] shift_next;
    logic [SHIFT_W-1:0] cur_shift;
    logic               pipe_valid;
    data_t              pipe_data;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [OUT_W-1:0]   fifo_rdata;
    logic [CNT_W:0]     credit_used;
    logic               accept;
    logic               pop;

    // Row in the stage register already owns a FIFO slot, so no comb path from output_ready.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pipe_valid};
    assign input_ready = reset && (credit_used < (CNT_W + 1)'(DEPTH));
    assign accept      = input_valid && input_ready;
    assign pop         = output_valid && output_ready;
    assign cur_shift   = (state == IDLE) ? shift_amt : shift_r;

    always_comb begin
        state_next  = state;
        in_row_next = in_row;
        shift_next  = shift_r;
        if (accept) begin
            case (state)
                IDLE: begin
                    shift_next = shift_amt;
                    if (ROWS > 1) begin
                        in_row_next = ROW_W'(1);
                        state_next  = BUSY;
                    end
                end
                BUSY: begin
                    if (in_row == LAST_ROW) begin
                        in_row_next = '0;
                        state_next  = IDLE;
                    end else begin
                        in_row_next = in_row + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            in_row     <= '0;
            shift_r    <= '0;
            pipe_valid <= 1'b0;
            pipe_data  <= '0;
            out_row    <= '0;
        end else begin
            state      <= state_next;
            in_row     <= in_row_next;
            shift_r    <= shift_next;
            pipe_valid <= accept;
            if (accept) begin
                pipe_data <= sat_round(input_data, cur_shift);
            end
            if (pop) begin
                out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pipe_valid),
        .pop   (pop),
        .wdata (pipe_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign output_valid = reset && !fifo_empty;
    assign output_data  = output_valid ? fifo_rdata : '0;
    assign output_last  = output_valid && (out_row == LAST_ROW);

endmodule

// File: tb/tb_mvm_requant_out.sv
// tb/tb_mvm_requant_out.sv - directed tables, backpressure, reset, throughput and random scoreboard (RELU_EN aware)
module tb_mvm_requant_out;

    logic               clk = 1'b0;
    logic               reset;
    logic               input_valid;
    logic               input_ready;
    logic [27:0]        input_data;
    logic [4:0]         shift_amt;
    logic               output_valid;
    logic               output_ready;
    logic signed [13:0] output_data;
    logic               output_last;

    mvm_requant_out dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .shift_amt    (shift_amt),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     last;
    } exp_t;

    typedef struct {
        longint d;
        int     s;
        longint e;
        longint er;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     in_cnt = 0;
    int     stalls = 0;
    exp_t   exp_q[$];
    int     acc_stamps[$];
    int     out_stamps[$];
    vec_t   tbl[48];
    bit     st_prev = 1'b0;
    longint st_d;
    bit     st_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint model(input longint x, input int s);
        longint r;
        int     sc;
        sc = (s > 27) ? 27 : s;
        if (sc == 0) r = x;
        else r = (x + (longint'(1) << (sc - 1))) >>> sc;
`ifdef RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 8191) r = 8191;
        if (r < -8192) r = -8192;
        return r;
    endfunction

    function automatic vec_t v(input longint d, input int s, input longint e, input longint er);
        vec_t t;
        t.d = d; t.s = s; t.e = e; t.er = er;
        return t;
    endfunction

    task automatic push_exp(input longint e);
        exp_t x;
        x.data = e;
        x.last = ((in_cnt % 8) == 7);
        exp_q.push_back(x);
        in_cnt++;
    endtask

    task automatic send(input longint d, input int s, input longint e);
        int w;
        w = 0;
        input_valid = 1'b1;
        input_data  = 28'(d);
        shift_amt   = 5'(s);
        do begin
            @(negedge clk);
            w++;
        end while (!input_ready && w < 300);
        if (!input_ready) begin
            chk("send_timeout", 0, 1);
            input_valid = 1'b0;
            return;
        end
        if (w > 1) stalls++;
        acc_stamps.push_back(cyc);
        push_exp(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int w;
        w = 0;
        output_ready = 1'b1;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk(nm, exp_q.size(), 0);
    endtask

    // Scoreboard and hold-while-stalled monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            st_prev = 1'b0;
        end else begin
            if (st_prev) chk("hold_stable", (output_valid && output_data == st_d && output_last == st_l), 1);
            if (output_valid && output_ready) begin
                out_stamps.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", output_data, 99999);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", output_data, e.data);
                    chk("out_last", output_last, e.last);
                end
            end
            st_prev = output_valid && !output_ready;
            st_d    = output_data;
            st_l    = output_last;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     acc;
        int     lat_s;
        bit     pend;
        int     guard;
        longint ex;
        logic signed [31:0] r32;

        // Rounding (shift 4), saturation (shift 0), shift clamp (28 -> 27), shift 1.
        tbl[0]  = v(24, 4, 2, 2);                tbl[1]  = v(-24, 4, -1, 0);
        tbl[2]  = v(7, 4, 0, 0);                 tbl[3]  = v(8, 4, 1, 1);
        tbl[4]  = v(-8, 4, 0, 0);                tbl[5]  = v(-9, 4, -1, 0);
        tbl[6]  = v(40, 4, 3, 3);                tbl[7]  = v(0, 4, 0, 0);
        tbl[8]  = v(134217727, 0, 8191, 8191);   tbl[9]  = v(-134217728, 0, -8192, 0);
        tbl[10] = v(8191, 0, 8191, 8191);        tbl[11] = v(-8193, 0, -8192, 0);
        tbl[12] = v(8192, 0, 8191, 8191);        tbl[13] = v(-8192, 0, -8192, 0);
        tbl[14] = v(0, 0, 0, 0);                 tbl[15] = v(-1, 0, -1, 0);
        tbl[16] = v(134217727, 28, 1, 1);        tbl[17] = v(-134217728, 28, -1, 0);
        tbl[18] = v(67108864, 28, 1, 1);         tbl[19] = v(67108863, 28, 0, 0);
        tbl[20] = v(-67108864, 28, 0, 0);        tbl[21] = v(-67108865, 28, -1, 0);
        tbl[22] = v(0, 28, 0, 0);                tbl[23] = v(5, 28, 0, 0);
        tbl[24] = v(1, 1, 1, 1);                 tbl[25] = v(-1, 1, 0, 0);
        tbl[26] = v(3, 1, 2, 2);                 tbl[27] = v(-3, 1, -1, 0);
        tbl[28] = v(16383, 1, 8191, 8191);       tbl[29] = v(-16385, 1, -8192, 0);
        tbl[30] = v(-16387, 1, -8192, 0);        tbl[31] = v(2, 1, 1, 1);
        // shift_amt moves 0 -> 2 after row 0: whole vector keeps shift 0.
        for (int i = 0; i < 8; i++) tbl[32 + i] = v(100 + i, (i == 0) ? 0 : 2, 100 + i, 100 + i);
        tbl[40] = v(100, 2, 25, 25);             tbl[41] = v(101, 2, 25, 25);
        tbl[42] = v(102, 2, 26, 26);             tbl[43] = v(103, 2, 26, 26);
        tbl[44] = v(104, 2, 26, 26);             tbl[45] = v(105, 2, 26, 26);
        tbl[46] = v(106, 2, 27, 27);             tbl[47] = v(107, 2, 27, 27);

        reset = 1'b0; input_valid = 1'b0; input_data = '0; shift_amt = '0; output_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("init_rst_ready", input_ready, 0);
            chk("init_rst_valid", output_valid, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", input_ready, 1);
        chk("post_rst_valid", output_valid, 0);
        chk("post_rst_data", output_data, 0);
        chk("post_rst_last", output_last, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 48; i++) begin
`ifdef RELU_EN
            ex = tbl[i].er;
`else
            ex = tbl[i].e;
`endif
            send(tbl[i].d, tbl[i].s, ex);
        end
        input_valid = 1'b0;
        drain("table_drain");

        // Backpressure: only DEPTH rows get credit while the consumer is stalled.
        output_ready = 1'b0;
        acc = 0;
        input_valid = 1'b1; shift_amt = '0; input_data = 28'(1000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (input_valid && input_ready) begin
                push_exp(1000 + acc);
                acc++;
            end
            @(posedge clk); #1;
            input_data = 28'(1000 + acc);
        end
        input_valid = 1'b0;
        chk("bp_accepted", acc, 8);
        chk("bp_ready_low", input_ready, 0);
        chk("bp_valid_held", output_valid, 1);
        output_ready = 1'b1;
        for (int i = acc; i < 10; i++) send(1000 + i, 0, 1000 + i);
        input_valid = 1'b0;
        drain("bp_drain");

        // Reset mid-vector with rows buffered and the FSM part-way through a vector.
        output_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(5 + i, 0, 5 + i);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", output_valid, 0);
            chk("rst_data", output_data, 0);
            chk("rst_last", output_last, 0);
            chk("rst_ready", input_ready, 0);
            @(posedge clk); #1;
        end
        in_cnt = 0;
        input_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_flushed", output_valid, 0);
        @(posedge clk); #1;
        output_ready = 1'b1;
`ifdef RELU_EN
        send(16, 3, 2); send(20, 0, 3); send(-20, 0, 0); send(4, 0, 1);
        send(3, 0, 0);  send(-4, 0, 0); send(-5, 0, 0);  send(800, 0, 100);
`else
        send(16, 3, 2); send(20, 0, 3); send(-20, 0, -2); send(4, 0, 1);
        send(3, 0, 0);  send(-4, 0, 0); send(-5, 0, -1);  send(800, 0, 100);
`endif
        input_valid = 1'b0;
        drain("rst_vec_drain");

        // Throughput: streaming with output_ready high.
        acc_stamps.delete();
        out_stamps.delete();
        stalls = 0;
        for (int i = 0; i < 16; i++) send(i * 37 - 300, 0, model(i * 37 - 300, 0));
        input_valid = 1'b0;
        drain("tp_drain");
        chk("tp_stalls", stalls, 0);
        if (acc_stamps.size() == 16 && out_stamps.size() == 16) begin
            chk("tp_latency", out_stamps[0] - acc_stamps[0], 2);
            chk("tp_in_span", acc_stamps[15] - acc_stamps[0], 15);
            chk("tp_out_span", out_stamps[15] - out_stamps[0], 15);
        end else begin
            chk("tp_stamp_count", out_stamps.size(), 16);
        end

        // Random valid/ready against the reference model.
        acc = 0; pend = 1'b0; guard = 0; lat_s = 0;
        input_valid = 1'b0;
        while (acc < 1000 && guard < 20000) begin
            output_ready = ($urandom_range(0, 9) < 7);
            if (!pend) begin
                if ($urandom_range(0, 9) < 7) begin
                    r32 = $urandom;
                    input_valid = 1'b1;
                    input_data  = 28'(r32 >>> $urandom_range(0, 16));
                    shift_amt   = 5'($urandom_range(0, 31));
                    pend = 1'b1;
                end else begin
                    input_valid = 1'b0;
                end
            end
            @(negedge clk);
            if (input_valid && input_ready) begin
                if ((in_cnt % 8) == 0) lat_s = int'(shift_amt);
                push_exp(model(longint'($signed(input_data)), lat_s));
                acc++;
                pend = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        input_valid = 1'b0;
        chk("rand_count", acc, 1000);
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
